// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: Moore T-state sequencer driving datapath strobes for fetch and ALU/mul/div execute
module alu_control_sequencer #(
   parameter logic [4:0] OP_NOP = 5'b01101,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             run,
   input  logic [31:0]      ir,
   output logic             PCout,
   output logic             MARin,
   output logic             IncPC,
   output logic             Zin,
   output logic             PCin,
   output logic             Read,
   output logic             MDRin,
   output logic             MDRout,
   output logic             IRin,
   output logic             Yin,
   output logic             Zlowout,
   output logic             Zhighout,
   output logic             LOin,
   output logic             HIin,
   output logic [15:0]      Rin,
   output logic [15:0]      Rout,
   output logic [4:0]       opcode,
   output logic             done,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count
);
   typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6} state_t;
   state_t           r_state, w_next, w_after;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ill;
   logic [4:0]       w_op;
   logic [3:0]       w_ra, w_rb, w_rc;
   logic             w_un, w_alu, w_md, w_ill, w_unused;
   assign w_op = ir[31:27];
   assign w_ra = ir[26:23];
   assign w_rb = ir[22:19];
   assign w_rc = ir[18:15];
   assign w_unused = ^ir[14:0];
   assign w_un = (w_op == 5'b10001) || (w_op == 5'b10010);
   assign w_alu = w_un || ((w_op >= 5'b00011) && (w_op <= 5'b01011));
   assign w_md = (w_op == 5'b01111) || (w_op == 5'b10000);
   assign w_ill = !w_alu && !w_md && (w_op != 5'b01101);
   assign w_after = run ? S_T0 : S_IDLE;
   assign instr_count = r_cnt;
   assign illegal = r_ill;
   always_comb begin
      {PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin} = '0;
      {Zlowout, Zhighout, LOin, HIin, done} = '0;
      Rin = '0;
      Rout = '0;
      opcode = OP_NOP;
      w_next = r_state;
      case (r_state)
         S_IDLE: w_next = run ? S_T0 : S_IDLE;
         S_T0: begin
            {PCout, MARin, IncPC, Zin} = '1;
            w_next = S_T1;
         end
         S_T1: begin
            {Zlowout, PCin, Read, MDRin} = '1;
            w_next = S_T2;
         end
         S_T2: begin
            {MDRout, IRin} = '1;
            w_next = S_T3;
         end
         S_T3: begin
            // nop and illegal codes retire here without touching the datapath
            if (w_alu || w_md) begin
               Rout = 16'd1 << (w_md ? w_ra : w_rb);
               Yin = 1'b1;
               w_next = S_T4;
            end else begin
               done = 1'b1;
               w_next = w_after;
            end
         end
         S_T4: begin
            Rout = 16'd1 << ((w_md || w_un) ? w_rb : w_rc);
            Zin = 1'b1;
            opcode = w_op;
            w_next = S_T5;
         end
         S_T5: begin
            Zlowout = 1'b1;
            if (w_md) begin
               LOin = 1'b1;
               w_next = S_T6;
            end else begin
               Rin = 16'd1 << w_ra;
               done = 1'b1;
               w_next = w_after;
            end
         end
         S_T6: begin
            {Zhighout, HIin, done} = '1;
            w_next = w_after;
         end
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         r_state <= S_IDLE;
         r_cnt <= '0;
         r_ill <= 1'b0;
      end else begin
         r_state <= w_next;
         if (done) r_cnt <= r_cnt + CNT_W'(1);
         if (r_state == S_T3 && w_ill) r_ill <= 1'b1;
      end
   end
endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb_alu_control_sequencer: scoreboard bench comparing every active cycle against per-instruction expected traces
module tb_alu_control_sequencer;
   localparam logic [4:0] NOPV = 5'b01101;
   localparam logic [14:0] S_T0 = 15'h7800, S_T1 = 15'h0710, S_T2 = 15'h00C0, S_Y = 15'h0020,
                           S_Z = 15'h0800, S_ZLD = 15'h0011, S_ZLO = 15'h0014, S_ZHI = 15'h000B, S_D = 15'h0001;
   logic clock = 1'b0, clear = 1'b1, run = 1'b0;
   logic [31:0] ir = '0;
   logic PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin;
   logic Zlowout, Zhighout, LOin, HIin, done, illegal;
   logic [15:0] Rin, Rout, instr_count;
   logic [4:0] opcode;
   typedef struct {logic [68:0] v; bit first;} ent_t;
   ent_t sb[$];
   logic [31:0] irq[$];
   int errors = 0, checks = 0;
   logic [15:0] m_cnt = '0;
   logic m_ill = 1'b0;

   alu_control_sequencer dut (
      .clock(clock), .clear(clear), .run(run), .ir(ir),
      .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .PCin(PCin), .Read(Read),
      .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zlowout(Zlowout),
      .Zhighout(Zhighout), .LOin(LOin), .HIin(HIin), .Rin(Rin), .Rout(Rout),
      .opcode(opcode), .done(done), .illegal(illegal), .instr_count(instr_count)
   );

   always #5 clock = ~clock;

   function automatic logic [68:0] act();
      return {PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
              Zlowout, Zhighout, LOin, HIin, done, illegal, Rin, Rout, opcode, instr_count};
   endfunction

   function automatic logic [68:0] ev(logic [14:0] s, logic [15:0] rin, logic [15:0] rout, logic [4:0] opc);
      return {s, m_ill, rin, rout, opc, m_cnt};
   endfunction

   function automatic logic [31:0] enc(logic [4:0] op, logic [3:0] ra, logic [3:0] rb, logic [3:0] rc);
      return {op, ra, rb, rc, 15'd0};
   endfunction

   task automatic push(input logic [31:0] v, input bit first, input int n);
      logic [4:0] op = v[31:27];
      logic [3:0] ra = v[26:23], rb = v[22:19], rc = v[18:15];
      logic [68:0] t[$];
      bit un, alu, md, ill;
      un = op inside {5'b10001, 5'b10010};
      alu = un || (op inside {[5'b00011:5'b01011]});
      md = op inside {5'b01111, 5'b10000};
      ill = !alu && !md && op != NOPV;
      t.push_back(ev(S_T0, 16'h0, 16'h0, NOPV));
      t.push_back(ev(S_T1, 16'h0, 16'h0, NOPV));
      t.push_back(ev(S_T2, 16'h0, 16'h0, NOPV));
      if (alu) begin
         t.push_back(ev(S_Y, 16'h0, 16'd1 << rb, NOPV));
         t.push_back(ev(S_Z, 16'h0, 16'd1 << (un ? rb : rc), op));
         t.push_back(ev(S_ZLD, 16'd1 << ra, 16'h0, NOPV));
      end else if (md) begin
         t.push_back(ev(S_Y, 16'h0, 16'd1 << ra, NOPV));
         t.push_back(ev(S_Z, 16'h0, 16'd1 << rb, op));
         t.push_back(ev(S_ZLO, 16'h0, 16'h0, NOPV));
         t.push_back(ev(S_ZHI, 16'h0, 16'h0, NOPV));
      end else t.push_back(ev(S_D, 16'h0, 16'h0, NOPV));
      for (int i = 0; i < t.size() && (n == 0 || i < n); i++) sb.push_back('{v: t[i], first: (first && i == 0)});
      irq.push_back(v);
      if (n == 0) begin
         m_cnt = m_cnt + 16'd1;
         if (ill) m_ill = 1'b1;
      end
   endtask

   task automatic chk(input string nm, input logic [68:0] a, input logic [68:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   task automatic start_one();
      @(negedge clock);
      run = 1'b1;
      @(negedge clock);
      run = 1'b0;
   endtask

   task automatic wait_count(input string nm, input logic [15:0] tgt, input int budget);
      int k = 0;
      while (instr_count !== tgt && k < budget) begin
         @(negedge clock);
         k++;
      end
      chk(nm, 69'(instr_count), 69'(tgt));
   endtask

   initial begin
      logic [15:0] base;
      fork
         begin
            int gap = 0;
            logic [68:0] a;
            ent_t e;
            forever begin
               @(negedge clock);
               a = act();
               if ((|a[68:54]) || (|a[52:21])) begin
                  checks++;
                  if (sb.size() == 0) begin
                     errors++;
                     $display("FAIL sb_extra: got %h expected no activity", a);
                  end else begin
                     e = sb.pop_front();
                     if (a !== e.v || (!e.first && gap != 0)) begin
                        errors++;
                        $display("FAIL sb_cycle: got %h after %0d idle cycles, expected %h", a, gap, e.v);
                     end
                  end
                  gap = 0;
                  if (IRin && irq.size() > 0) ir = irq.pop_front();
               end else gap++;
            end
         end
      join_none
      #1 clear = 1'b0;
      #1 chk("reset_init", act(), ev(15'h0, 16'h0, 16'h0, NOPV));
      repeat (2) @(negedge clock);
      clear = 1'b1;
      push(32'h5918_8000, 1'b1, 0);
      start_one();
      wait_count("or_count", 16'd1, 20);
      push(enc(5'b01111, 4'd4, 4'd5, 4'd0), 1'b1, 0);
      start_one();
      wait_count("mul_count", 16'd2, 20);
      push(enc(5'b11111, 4'd1, 4'd2, 4'd3), 1'b1, 0);
      start_one();
      wait_count("ill_count", 16'd3, 20);
      chk("illegal_set", 69'(illegal), 69'(1));
      push(enc(5'b00011, 4'd6, 4'd7, 4'd8), 1'b1, 0);
      start_one();
      wait_count("add_count", 16'd4, 20);
      chk("illegal_sticky", 69'(illegal), 69'(1));
      push(enc(5'b10001, 4'd9, 4'd10, 4'd15), 1'b1, 0);
      start_one();
      wait_count("neg_count", 16'd5, 20);
      push(enc(5'b10000, 4'd14, 4'd15, 4'd0), 1'b1, 0);
      start_one();
      wait_count("div_count", 16'd6, 20);
      push(enc(NOPV, 4'd0, 4'd0, 4'd0), 1'b1, 0);
      start_one();
      wait_count("nop_count", 16'd7, 20);
      base = m_cnt;
      push(enc(5'b00011, 4'd1, 4'd2, 4'd3), 1'b1, 0);
      push(enc(5'b00011, 4'd4, 4'd5, 4'd6), 1'b0, 0);
      push(enc(5'b00011, 4'd7, 4'd8, 4'd9), 1'b0, 0);
      push(enc(5'b00011, 4'd10, 4'd11, 4'd12), 1'b0, 0);
      @(negedge clock);
      run = 1'b1;
      wait_count("batch3_count", base + 16'd3, 40);
      for (int k = 0; k < 20 && !IRin; k++) @(negedge clock);
      run = 1'b0;
      wait_count("batch4_count", base + 16'd4, 20);
      repeat (3) @(negedge clock);
      chk("idle_after_drop", act(), ev(15'h0, 16'h0, 16'h0, NOPV));
      push(enc(5'b00011, 4'd3, 4'd4, 4'd5), 1'b1, 5);
      start_one();
      for (int k = 0; k < 20 && opcode !== 5'b00011; k++) @(negedge clock);
      chk("abort_in_t4", 69'(opcode), 69'(5'b00011));
      #2 clear = 1'b0;
      m_cnt = '0;
      m_ill = 1'b0;
      #1 chk("reset_mid_t4", act(), ev(15'h0, 16'h0, 16'h0, NOPV));
      @(negedge clock);
      clear = 1'b1;
      repeat (2) @(negedge clock);
      chk("idle_after_reset", act(), ev(15'h0, 16'h0, 16'h0, NOPV));
      force dut.r_cnt = 16'hFFFF;
      @(negedge clock);
      release dut.r_cnt;
      m_cnt = 16'hFFFF;
      push(enc(NOPV, 4'd0, 4'd0, 4'd0), 1'b1, 0);
      start_one();
      wait_count("wrap_count", 16'h0000, 20);
      repeat (2) @(negedge clock);
      chk("sb_drained", 69'(sb.size()), 69'(0));
      chk("ir_drained", 69'(irq.size()), 69'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alu_control_sequencer.md
# alu_control_sequencer

Moore control sequencer that drives the datapath's control inputs for instruction fetch and register-register ALU, multiply and divide execution. It sits directly upstream of the datapath and replaces hand-sequenced T0–T6 stimulus with a state machine that decodes the fetched IR. One instruction executes per pass through the T-states. The block also keeps a retired-instruction counter and a sticky illegal-opcode flag.

## Interface
Parameters:
- OP_NOP, 5'b01101, opcode driven to the ALU whenever no operation is selected
- CNT_W, 16, retired-instruction counter width

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = keep fetching/executing
- ir  in  32  datapath IR contents; valid from T3 until the next T2
- PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin  out  1 each  datapath strobes
- Zlowout, Zhighout, LOin, HIin  out  1 each  Z/HI/LO strobes
- Rin  out  16  one-hot register load enables, bit n = Rn
- Rout  out  16  one-hot register bus drive, bit n = Rn
- opcode  out  5  ALU operation select
- done  out  1  one-cycle pulse in the final state of each instruction
- illegal  out  1  sticky; set on an undefined opcode
- instr_count  out  CNT_W  retired instructions, wraps

## Operation
IR fields:
- op = ir[31:27], Ra = ir[26:23], Rb = ir[22:19], Rc = ir[18:15]

Opcode classes:
- Binary ALU: add 00011, sub 00100, shr 00101, shra 00110, shl 00111, ror 01000, rol 01001, and 01010, or 01011
- Unary ALU (Rc ignored): neg 10001, not 10010
- Mul/div: mul 01111, div 10000
- Nop: 01101
- All other codes: illegal, executed as nop

States are IDLE, T0–T6, each one cycle. Outputs are pure decode of the state register and the ir fields. Every strobe not listed for a state is 0, and opcode = OP_NOP except in T4.
- IDLE: no strobes. Go to T0 when run = 1.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin.
- T2: MDRout, IRin.
- T3 by class:
  - ALU: Rout[Rb], Yin.
  - Mul/div: Rout[Ra], Yin.
  - Nop/illegal: no strobes, done = 1.
- T4 by class:
  - Binary ALU: Rout[Rc], Zin, opcode = op.
  - Unary ALU: Rout[Rb], Zin, opcode = op.
  - Mul/div: Rout[Rb], Zin, opcode = op.
- T5 by class:
  - ALU: Zlowout, Rin[Ra], done = 1.
  - Mul/div: Zlowout, LOin.
- T6 (mul/div only): Zhighout, HIin, done = 1.
- After the state that asserts done: go to T0 if run = 1, else IDLE.
- Dropping run mid-instruction does not abort it. The instruction completes, then the sequencer returns to IDLE.

Counter and flag:
- instr_count increments by 1 on the clock edge that ends each done cycle. It wraps from all-ones to 0.
- illegal is set on the edge ending a T3 whose op is illegal. It stays set until clear.

Reset:
- clear = 0 asynchronously forces state IDLE, all strobes 0, Rin = Rout = 0, opcode = OP_NOP, done = 0, illegal = 0, instr_count = 0.
- Reset mid-instruction abandons the instruction with no count increment.

## Timing
- Cycles per instruction, counted from entry to T0 up to and including the done cycle:
  - Fetch alone: 3.
  - Nop/illegal: 4.
  - ALU: 6.
  - Mul/div: 7.
- Back-to-back instructions with run held at 1: T0 immediately follows the done cycle, with no bubble.
- IDLE to T0 takes one edge after run = 1 is sampled.
- ir is sampled combinationally from T3 onward. The datapath loads IR on the edge ending T2, so ir must be stable by T3.
- Rin and Rout are always one-hot or zero. Never more than one bit of Rout is set.
- clear deassertion is synchronous in effect: the first state transition happens on the first rising edge after clear = 1.

## Test plan
- Reset: clear = 0 mid-T4 of an add → all outputs 0 within the same cycle, opcode = 01101, instr_count = 0, state IDLE.
- OR instruction: run = 1, ir = 32'h5918_8000 (or R2, R3, R1 encoding: op 01011, Ra = 2, Rb = 3, Rc = 1) → T3: Rout = 16'h0008 with Yin; T4: Rout = 16'h0002, Zin, opcode = 01011; T5: Zlowout, Rin = 16'h0004, done; count = 1.
- mul: op 01111, Ra = 4, Rb = 5 → T3: Rout = 16'h0010; T4: Rout = 16'h0020, opcode = 01111; T5: LOin; T6: HIin with done. Total 7 cycles.
- Illegal: op 11111 → T3: done = 1, illegal latches to 1. It stays 1 across a following valid add.
- Run control: run held at 1 for three adds → done every 6 cycles, no bubble, count = 3. Drop run during T2 of the fourth add → that add completes, count = 4, then IDLE.
- Wrap: preload the counter to 16'hFFFF via 65535 nops (or a force), execute one nop → instr_count = 0.
